// File: rtl/dict_id_unpacker.sv
// Unpacks a byte stream of LSB-first bit-packed dictionary IDs into beats of
// NUM_ELEMENTS zero-extended ID lanes with per-lane keep and a stream last.
module dict_id_unpacker #(
    parameter int ID_BITS      = 16,
    parameter int NUM_ELEMENTS = 16,
    parameter int IN_BYTES     = 64,
    parameter int BW_BITS      = $clog2(ID_BITS) + 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [BW_BITS-1:0]              cfg_bit_width,
    input  logic [IN_BYTES*8-1:0]           in_data,
    input  logic [IN_BYTES-1:0]             in_keep,
    input  logic                            in_last,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [NUM_ELEMENTS*ID_BITS-1:0] out_data,
    output logic [NUM_ELEMENTS-1:0]         out_keep,
    output logic                            out_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            err_bad_width
);
    localparam int IN_W     = IN_BYTES * 8;
    localparam int OUT_W    = NUM_ELEMENTS * ID_BITS;
    localparam int BUF_BITS = IN_W + OUT_W;
    localparam int CNT_W    = $clog2(BUF_BITS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DROP} state_t;

    state_t                  state_q, state_d;
    logic [BUF_BITS-1:0]     buf_q, buf_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BW_BITS-1:0]      bw_q, bw_d;
    logic                    last_sent_q, last_sent_d;
    logic                    err_q, err_d;
    logic                    in_ready_q, in_ready_d;

    logic [OUT_W-1:0]        out_data_q;
    logic [NUM_ELEMENTS-1:0] out_keep_q;
    logic                    out_last_q, out_valid_q;

    logic                    in_fire, out_free, cfg_ok;
    logic [IN_W-1:0]         in_bits;
    logic [CNT_W-1:0]        in_add, full_bits, consumed, base;
    logic [ID_BITS-1:0]      id_mask;
    logic [NUM_ELEMENTS-1:0] lane_fit;
    logic [OUT_W-1:0]        lane_data;
    logic                    emit, emit_last, append, discard;

    assign in_fire   = in_valid && in_ready_q;
    assign out_free  = !out_valid_q || out_ready;
    assign full_bits = CNT_W'(NUM_ELEMENTS) * CNT_W'(bw_q);
    assign cfg_ok    = (cfg_bit_width != '0) && (cfg_bit_width <= BW_BITS'(ID_BITS));
    assign id_mask   = ID_BITS'((32'd1 << bw_q) - 32'd1);

    // Unkept bytes are zeroed so they can never leak into the accumulator.
    always_comb begin
        in_bits = '0;
        in_add  = '0;
        for (int b = 0; b < IN_BYTES; b++) begin
            if (in_keep[b]) begin
                in_bits[b*8 +: 8] = in_data[b*8 +: 8];
                in_add            = in_add + CNT_W'(8);
            end
        end
    end

    // Lane i is valid when its whole ID is buffered; a full beat has every lane valid.
    always_comb begin
        lane_data = '0;
        lane_fit  = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            lane_fit[i] = (CNT_W'(i + 1) * CNT_W'(bw_q)) <= cnt_q;
            if (lane_fit[i])
                lane_data[i*ID_BITS +: ID_BITS] =
                    ID_BITS'(buf_q[OUT_W-1:0] >> (i * int'(bw_q))) & id_mask;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        bw_d        = bw_q;
        last_sent_d = last_sent_q;
        err_d       = err_q;
        emit        = 1'b0;
        emit_last   = 1'b0;
        append      = 1'b0;
        discard     = 1'b0;
        consumed    = '0;

        unique case (state_q)
            IDLE: begin
                if (in_fire) begin
                    bw_d = cfg_bit_width;
                    if (!cfg_ok) begin
                        err_d   = 1'b1;
                        state_d = in_last ? IDLE : DROP;
                    end else begin
                        append  = 1'b1;
                        state_d = in_last ? DRAIN : RUN;
                    end
                end
            end
            RUN: begin
                append = in_fire;
                if (out_free && cnt_q >= full_bits) begin
                    emit     = 1'b1;
                    consumed = full_bits;
                end
                if (in_fire && in_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (last_sent_q) begin
                    if (out_valid_q && out_ready) begin
                        last_sent_d = 1'b0;
                        state_d     = IDLE;
                    end
                end else if (out_free) begin
                    emit = 1'b1;
                    if (cnt_q >= full_bits) begin
                        consumed  = full_bits;
                        emit_last = (cnt_q == full_bits);
                    end else begin
                        // Partial or empty closing beat; leftover bits shorter than one ID are dropped.
                        discard   = 1'b1;
                        emit_last = 1'b1;
                    end
                    last_sent_d = emit_last;
                end
            end
            DROP: begin
                if (in_fire && in_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        base = cnt_q - consumed;
        if (discard) begin
            buf_d = '0;
            cnt_d = '0;
        end else begin
            buf_d = buf_q >> consumed;
            cnt_d = base;
        end
        if (append) begin
            buf_d = buf_d | (BUF_BITS'(in_bits) << base);
            cnt_d = cnt_d + in_add;
        end

        // Registered ready: only offer a beat when a whole input beat is guaranteed to fit.
        in_ready_d = (state_d != DRAIN) && (cnt_d <= CNT_W'(BUF_BITS - IN_W));
    end

    // NOTE: the accumulator is reset as well: appends OR into it, so bits above cnt must be zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            cnt_q       <= '0;
            bw_q        <= '0;
            last_sent_q <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            bw_q        <= bw_d;
            last_sent_q <= last_sent_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else if (emit) begin
            out_valid_q <= 1'b1;
            out_keep_q  <= lane_fit;
            out_last_q  <= emit_last;
            out_data_q  <= lane_data;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_data      = out_data_q;
    assign out_keep      = out_keep_q;
    assign out_last      = out_last_q;
    assign out_valid     = out_valid_q;
    assign err_bad_width = err_q;

endmodule
